// File: rtl/axi_pkg.sv
// Shared AXI interconnect definitions: default channel widths, RRESP codes and
// the R-channel router state type.
package axi_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_DATA_BITS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE,
    LOCK
  } r_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: returns the first asserted request found when scanning
// from ptr_i upwards, wrapping modulo N. Purely combinational.
//   req_i     : request vector
//   ptr_i     : index that has highest priority this cycle (must be < N)
//   win_o     : index of the selected request (0 when none)
//   any_req_o : at least one request asserted
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] win_o,
  output logic         any_req_o
);

  logic [31:0] idx;

  always_comb begin
    idx       = '0;
    win_o     = '0;
    any_req_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!any_req_o && req_i[W'(idx)]) begin
        any_req_o = 1'b1;
        win_o     = W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_r_router.sv
// AXI R-channel crossbar. Slaves are arbitrated round-robin; the winner keeps
// the path until its RLAST beat is accepted, so bursts never interleave. Each
// beat goes to the master selected by the RID bits just above the master ID;
// beats naming a nonexistent master are accepted and dropped.
//   clk, rst (async, active-low)
//   RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S, RREADY_S : slave-side R channels
//   RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M, RREADY_M : master-side R channels
//   drop_o : one-cycle pulse per absorbed (unroutable) beat
module axi_r_router
  import axi_pkg::*;
#(
  parameter int unsigned NUM_S     = 3,
  parameter int unsigned NUM_M     = 2,
  parameter int unsigned ID_BITS   = AXI_ID_BITS,
  parameter int unsigned IDS_BITS  = AXI_IDS_BITS,
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  localparam int unsigned MIDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int unsigned SW       = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_S-1:0][IDS_BITS-1:0]     RID_S,
  input  logic [NUM_S-1:0][DATA_BITS-1:0]    RDATA_S,
  input  logic [NUM_S-1:0][1:0]              RRESP_S,
  input  logic [NUM_S-1:0]                   RLAST_S,
  input  logic [NUM_S-1:0]                   RVALID_S,
  output logic [NUM_S-1:0]                   RREADY_S,
  output logic [NUM_M-1:0][ID_BITS-1:0]      RID_M,
  output logic [NUM_M-1:0][DATA_BITS-1:0]    RDATA_M,
  output logic [NUM_M-1:0][1:0]              RRESP_M,
  output logic [NUM_M-1:0]                   RLAST_M,
  output logic [NUM_M-1:0]                   RVALID_M,
  input  logic [NUM_M-1:0]                   RREADY_M,
  output logic                               drop_o
);

  r_state_e            st_q, st_d;
  logic [SW-1:0]       gnt_q, gnt_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [SW-1:0]       pick_win;
  logic                pick_any;
  logic [SW-1:0]       win;
  logic                active;
  logic                hs;
  logic [IDS_BITS-1:0] win_rid;
  logic [MIDX_W-1:0]   dst;
  logic                routable;
  logic                unused_rid;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    return (32'(v) == NUM_S - 1) ? '0 : v + SW'(1);
  endfunction

  rr_pick #(
    .N (NUM_S)
  ) u_rr_pick (
    .req_i     (RVALID_S),
    .ptr_i     (ptr_q),
    .win_o     (pick_win),
    .any_req_o (pick_any)
  );

  // In LOCK the path stays on gnt even while its RVALID is low.
  assign win      = (st_q == LOCK) ? gnt_q : pick_win;
  assign active   = (st_q == LOCK) || pick_any;
  assign win_rid  = RID_S[win];
  assign dst      = win_rid[ID_BITS +: MIDX_W];
  assign routable = (32'(dst) < NUM_M);

  // Bits above the routing field carry no meaning for this router.
  assign unused_rid = ^win_rid;

  // Payload is broadcast; only RVALID_M selects the destination.
  assign RID_M   = {NUM_M{win_rid[ID_BITS-1:0]}};
  assign RDATA_M = {NUM_M{RDATA_S[win]}};
  assign RRESP_M = {NUM_M{RRESP_S[win]}};
  assign RLAST_M = {NUM_M{RLAST_S[win]}};

  // Handshake outputs are forced low during reset so nothing is accepted.
  always_comb begin
    RVALID_M = '0;
    RREADY_S = '0;
    drop_o   = 1'b0;
    if (rst && active) begin
      if (routable) begin
        RVALID_M[dst] = RVALID_S[win];
        RREADY_S[win] = RREADY_M[dst];
      end else begin
        RREADY_S[win] = 1'b1;
        drop_o        = RVALID_S[win];
      end
    end
    hs = RVALID_S[win] & RREADY_S[win];
  end

  always_comb begin
    st_d  = st_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    case (st_q)
      IDLE: begin
        if (pick_any) begin
          if (hs && RLAST_S[win]) begin
            ptr_d = wrap_inc(win);
          end else begin
            // Lock also on a stalled first beat so the selection cannot move.
            st_d  = LOCK;
            gnt_d = win;
          end
        end
      end
      LOCK: begin
        if (hs && RLAST_S[win]) begin
          st_d  = IDLE;
          ptr_d = wrap_inc(gnt_q);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      st_q  <= st_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axi_r_router.sv
module tb_axi_r_router;
  import axi_pkg::*;

  localparam int NS = 3;
  localparam int NM = 3;  // 2-bit routing field: index 3 names no master

  typedef struct {
    logic [7:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [NS-1:0] rready_s;
    logic [NM-1:0] rvalid_m;
    logic          drop;
    logic [3:0]    id;
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
  } rec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NS-1:0][7:0]    rid_s;
  logic [NS-1:0][31:0]   rdata_s;
  logic [NS-1:0][1:0]    rresp_s;
  logic [NS-1:0]         rlast_s;
  logic [NS-1:0]         rvalid_s;
  logic [NS-1:0]         rready_s;
  logic [NM-1:0][3:0]    rid_m;
  logic [NM-1:0][31:0]   rdata_m;
  logic [NM-1:0][1:0]    rresp_m;
  logic [NM-1:0]         rlast_m;
  logic [NM-1:0]         rvalid_m;
  logic [NM-1:0]         rready_m;
  logic                  drop;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sq[NS][$];
  bit    vld[NS];
  rec_t  exp_q[$];
  int    owner   = -1;
  int    rr_next = 0;

  axi_r_router #(
    .NUM_S     (NS),
    .NUM_M     (NM),
    .ID_BITS   (4),
    .IDS_BITS  (8),
    .DATA_BITS (32)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .RID_S    (rid_s),
    .RDATA_S  (rdata_s),
    .RRESP_S  (rresp_s),
    .RLAST_S  (rlast_s),
    .RVALID_S (rvalid_s),
    .RREADY_S (rready_s),
    .RID_M    (rid_m),
    .RDATA_M  (rdata_m),
    .RRESP_M  (rresp_m),
    .RLAST_M  (rlast_m),
    .RVALID_M (rvalid_m),
    .RREADY_M (rready_m),
    .drop_o   (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the owner of an unfinished burst keeps the path; otherwise the
  // first valid slave at or after rr_next wins. Winner's RID bits [5:4] route.
  function automatic void model_step();
    rec_t r;
    int   w;
    int   dst;
    r.rready_s = '0;
    r.rvalid_m = '0;
    r.drop     = 1'b0;
    r.id       = '0;
    r.data     = '0;
    r.resp     = '0;
    r.last     = 1'b0;
    if (!rst_n) begin
      owner   = -1;
      rr_next = 0;
    end else begin
      w = owner;
      if (w < 0) begin
        for (int k = 0; k < NS; k++) begin
          if (w < 0 && rvalid_s[(rr_next + k) % NS]) w = (rr_next + k) % NS;
        end
      end
      if (w >= 0) begin
        dst    = int'(rid_s[w][5:4]);
        r.id   = rid_s[w][3:0];
        r.data = rdata_s[w];
        r.resp = rresp_s[w];
        r.last = rlast_s[w];
        if (dst < NM) begin
          r.rvalid_m[dst] = rvalid_s[w];
          r.rready_s[w]   = rready_m[dst];
        end else begin
          r.rready_s[w] = 1'b1;
          r.drop        = rvalid_s[w];
        end
        if (rvalid_s[w] && r.rready_s[w] && rlast_s[w]) begin
          owner   = -1;
          rr_next = (w + 1) % NS;
        end else begin
          owner = w;
        end
      end
    end
    exp_q.push_back(r);
  endfunction

  // One cycle: drive at negedge, model at +1, monitor at +2, slave pops at +3.
  task automatic step(input int vprob, input int rprob, input logic rst_val);
    @(negedge clk);
    rst_n = rst_val;
    for (int i = 0; i < NS; i++) begin
      if (!vld[i] && sq[i].size() > 0 && int'($urandom_range(0, 99)) < vprob) vld[i] = 1'b1;
      rvalid_s[i] = vld[i];
      if (vld[i]) begin
        rid_s[i]   = sq[i][0].rid;
        rdata_s[i] = sq[i][0].data;
        rresp_s[i] = sq[i][0].resp;
        rlast_s[i] = sq[i][0].last;
      end else begin
        rid_s[i]   = 8'($urandom);
        rdata_s[i] = $urandom;
        rresp_s[i] = 2'($urandom);
        rlast_s[i] = 1'($urandom);
      end
    end
    for (int m = 0; m < NM; m++) rready_m[m] = int'($urandom_range(0, 99)) < rprob;
    #1;
    model_step();
    #2;
    for (int i = 0; i < NS; i++) begin
      if (rvalid_s[i] && rready_s[i]) begin
        void'(sq[i].pop_front());
        vld[i] = 1'b0;
      end
    end
  endtask

  task automatic gen_burst(input int s, input logic [7:0] rid, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.rid  = rid;
      bt.data = $urandom;
      bt.resp = (b == 0) ? RESP_OKAY : 2'($urandom);
      bt.last = (b == len - 1);
      sq[s].push_back(bt);
    end
  endtask

  task automatic drain();
    int budget;
    int left;
    budget = 400;
    left   = sq[0].size() + sq[1].size() + sq[2].size();
    while (left > 0 && budget > 0) begin
      step(100, 100, 1'b1);
      budget--;
      left = sq[0].size() + sq[1].size() + sq[2].size();
    end
    chk("drain_beats_left", 64'(left), 64'(0));
  endtask

  // Monitor: compares every cycle the model predicted against the DUT.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("rready_s", 64'(rready_s), 64'(r.rready_s));
        chk("rvalid_m", 64'(rvalid_m), 64'(r.rvalid_m));
        chk("drop_o", 64'(drop), 64'(r.drop));
        if (r.rvalid_m != '0) begin
          for (int m = 0; m < NM; m++) begin
            if (r.rvalid_m[m]) begin
              chk("rid_m", 64'(rid_m[m]), 64'(r.id));
              chk("rlast_m", 64'(rlast_m[m]), 64'(r.last));
              chk("rresp_m", 64'(rresp_m[m]), 64'(r.resp));
            end
            chk("rdata_m", 64'(rdata_m[m]), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    rid_s    = '0;
    rdata_s  = '0;
    rresp_s  = '0;
    rlast_s  = '0;
    rvalid_s = '0;
    rready_m = '0;
    for (int i = 0; i < NS; i++) vld[i] = 1'b0;

    // Held in reset with requests pending: nothing may be accepted.
    gen_burst(0, 8'h03, 2);
    gen_burst(2, 8'h15, 1);
    repeat (3) step(100, 100, 1'b0);
    drain();

    // Single slave 1, dst 1, 4-beat burst.
    gen_burst(1, 8'h14, 4);
    drain();

    // All three slaves with single-beat bursts, masters always ready.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NS; s++) gen_burst(s, {2'b00, 2'(s % 2), 4'(s + r)}, 1);
    end
    drain();

    // Slave 0 mid-burst, then slave 2 requests.
    gen_burst(0, 8'h07, 4);
    repeat (2) step(100, 100, 1'b1);
    gen_burst(2, 8'h1a, 2);
    drain();

    // Master stall on a first beat while others request.
    gen_burst(0, 8'h21, 3);
    gen_burst(1, 8'h02, 2);
    gen_burst(2, 8'h11, 1);
    repeat (5) step(100, 0, 1'b1);
    drain();

    // Unroutable bursts are absorbed; arbitration continues afterwards.
    gen_burst(2, 8'h35, 3);
    gen_burst(0, 8'hf9, 2);
    gen_burst(1, 8'h06, 1);
    drain();

    // Reset during beat 2 of a 4-beat burst.
    gen_burst(0, 8'h0c, 4);
    gen_burst(1, 8'h18, 1);
    repeat (2) step(100, 100, 1'b1);
    repeat (2) step(100, 100, 1'b0);
    drain();

    // Randomized traffic with stalls, drops and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 25) begin
        gen_burst(int'($urandom_range(0, NS - 1)), 8'($urandom), int'($urandom_range(1, 5)));
      end
      step(70, 70, ($urandom_range(0, 299) != 0));
    end
    drain();

    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
